// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the IFU (read-only) and LSU (read/write).
// Each transaction walks IDLE -> [WAIT] -> ISSUE -> RESP, so men pulses exactly once.
module mem_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MASK_W  = 8,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stop,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_wen,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              men,
    output logic              mwen,
    output logic [ADDR_W-1:0] raddr,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic [MASK_W-1:0] wmask,
    input  logic [DATA_W-1:0] rdata,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_RESP} state_t;
    typedef enum logic {GNT_IFU, GNT_LSU} gnt_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t             state_q, state_d;
    gnt_t               last_grant_q, gid_q, pick;
    logic               accept;
    logic [3:0]         cnt_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               wen_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [MASK_W-1:0]  wmask_q;
    logic [DATA_W-1:0]  ifu_rdata_q, lsu_rdata_q;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        pick          = GNT_IFU;
        accept        = 1'b0;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        men           = 1'b0;
        mwen          = 1'b0;
        raddr         = '0;
        waddr         = '0;
        wdata         = '0;
        wmask         = '0;
        case (state_q)
            S_IDLE: begin
                if (!stop && (ifu_req_valid || lsu_req_valid)) begin
                    // On a tie the requester not served last time wins.
                    if (ifu_req_valid && lsu_req_valid)
                        pick = (last_grant_q == GNT_IFU) ? GNT_LSU : GNT_IFU;
                    else if (lsu_req_valid)
                        pick = GNT_LSU;
                    accept        = 1'b1;
                    ifu_req_ready = (pick == GNT_IFU);
                    lsu_req_ready = (pick == GNT_LSU);
                    state_d       = (CNT_INIT != 4'd0) ? S_WAIT : S_ISSUE;
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1)
                    state_d = S_ISSUE;
            end
            S_ISSUE: begin
                men  = 1'b1;
                mwen = wen_q;
                if (wen_q) begin
                    waddr = addr_q;
                    wdata = wdata_q;
                    wmask = wmask_q;
                end else begin
                    raddr = addr_q;
                end
                state_d = S_RESP;
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= GNT_LSU;
            gid_q        <= GNT_IFU;
            cnt_q        <= '0;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            ifu_rdata_q  <= '0;
            lsu_rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                gid_q        <= pick;
                last_grant_q <= pick;
                cnt_q        <= CNT_INIT;
                addr_q       <= (pick == GNT_IFU) ? ifu_addr : lsu_addr;
                wen_q        <= (pick == GNT_LSU) && lsu_wen;
                wdata_q      <= (pick == GNT_LSU) ? lsu_wdata : '0;
                wmask_q      <= (pick == GNT_LSU) ? lsu_wmask : '0;
            end
            if (state_q == S_WAIT)
                cnt_q <= cnt_q - 4'd1;
            // Response data is captured during ISSUE and held until the next response.
            if (state_q == S_ISSUE) begin
                if (gid_q == GNT_IFU)
                    ifu_rdata_q <= rdata;
                else
                    lsu_rdata_q <= wen_q ? '0 : rdata;
            end
        end
    end

    assign ifu_resp_valid = (state_q == S_RESP) && (gid_q == GNT_IFU);
    assign lsu_resp_valid = (state_q == S_RESP) && (gid_q == GNT_LSU);
    assign ifu_rdata      = ifu_rdata_q;
    assign lsu_rdata      = lsu_rdata_q;
    assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at LATENCY=1, one at LATENCY=3,
// both fed from the same request inputs, each with its own memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst, stop;
    logic        ifu_req_valid, lsu_req_valid, lsu_wen;
    logic [63:0] ifu_addr, lsu_addr, lsu_wdata;
    logic [7:0]  lsu_wmask;

    logic        ifu_req_ready_l1, lsu_req_ready_l1, ifu_resp_valid_l1, lsu_resp_valid_l1;
    logic        men_l1, mwen_l1, busy_l1;
    logic [63:0] ifu_rdata_l1, lsu_rdata_l1, raddr_l1, waddr_l1, wdata_l1, rdata_l1;
    logic [7:0]  wmask_l1;

    logic        ifu_req_ready_l3, lsu_req_ready_l3, ifu_resp_valid_l3, lsu_resp_valid_l3;
    logic        men_l3, mwen_l3, busy_l3;
    logic [63:0] ifu_rdata_l3, lsu_rdata_l3, raddr_l3, waddr_l3, wdata_l3, rdata_l3;
    logic [7:0]  wmask_l3;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_fn(input logic [63:0] a);
        if (a == 64'h0000_0000_8000_0000)
            return 64'h0000_0413_0010_0093;
        return a ^ 64'hC0FF_EE00_1234_5678;
    endfunction

    assign rdata_l1 = mem_fn(raddr_l1);
    assign rdata_l3 = mem_fn(raddr_l3);

    mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MASK_W(8), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .stop(stop),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready_l1), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid_l1), .ifu_rdata(ifu_rdata_l1),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready_l1), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid_l1), .lsu_rdata(lsu_rdata_l1),
        .men(men_l1), .mwen(mwen_l1), .raddr(raddr_l1), .waddr(waddr_l1),
        .wdata(wdata_l1), .wmask(wmask_l1), .rdata(rdata_l1), .busy(busy_l1)
    );

    mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MASK_W(8), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .stop(stop),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready_l3), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid_l3), .ifu_rdata(ifu_rdata_l3),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready_l3), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid_l3), .lsu_rdata(lsu_rdata_l3),
        .men(men_l3), .mwen(mwen_l3), .raddr(raddr_l3), .waddr(waddr_l3),
        .wdata(wdata_l3), .wmask(wmask_l3), .rdata(rdata_l3), .busy(busy_l3)
    );

    // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; stop = 1'b0;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; lsu_wen = 1'b0;
        ifu_addr = '0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if ({ifu_req_ready_l1, lsu_req_ready_l1, ifu_resp_valid_l1, lsu_resp_valid_l1, men_l1, mwen_l1, busy_l1} !== 7'b0) begin n_mis++; $display("FAIL reset_ctrl: got %b want 0", {ifu_req_ready_l1, lsu_req_ready_l1, ifu_resp_valid_l1, lsu_resp_valid_l1, men_l1, mwen_l1, busy_l1}); end
        n_cmp++; if ({raddr_l1, waddr_l1, wdata_l1, wmask_l1} !== '0) begin n_mis++; $display("FAIL reset_mem_port: got %h want 0", {raddr_l1, waddr_l1, wdata_l1, wmask_l1}); end
        n_cmp++; if ({ifu_rdata_l1, lsu_rdata_l1} !== '0) begin n_mis++; $display("FAIL reset_rdata: got %h want 0", {ifu_rdata_l1, lsu_rdata_l1}); end
        n_cmp++; if (busy_l3 !== 1'b0) begin n_mis++; $display("FAIL reset_busy_l3: got %b want 0", busy_l3); end
    endtask

    task automatic test_ifu_read();
        do_reset();
        ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0000;
        #1;
        n_cmp++; if ({ifu_req_ready_l1, lsu_req_ready_l1} !== 2'b10) begin n_mis++; $display("FAIL ifu_rd_ready: got %b want 10", {ifu_req_ready_l1, lsu_req_ready_l1}); end
        step();
        ifu_req_valid = 1'b0;
        #1;
        n_cmp++; if ({men_l1, mwen_l1, lsu_resp_valid_l1, ifu_req_ready_l1} !== 4'b1000) begin n_mis++; $display("FAIL ifu_rd_issue_ctrl: got %b want 1000", {men_l1, mwen_l1, lsu_resp_valid_l1, ifu_req_ready_l1}); end
        n_cmp++; if ({raddr_l1, waddr_l1} !== {64'h8000_0000, 64'h0}) begin n_mis++; $display("FAIL ifu_rd_issue_addr: got %h want %h", {raddr_l1, waddr_l1}, {64'h8000_0000, 64'h0}); end
        step();
        #1;
        n_cmp++; if ({ifu_resp_valid_l1, lsu_resp_valid_l1, men_l1} !== 3'b100) begin n_mis++; $display("FAIL ifu_rd_resp: got %b want 100", {ifu_resp_valid_l1, lsu_resp_valid_l1, men_l1}); end
        n_cmp++; if (ifu_rdata_l1 !== 64'h0000_0413_0010_0093) begin n_mis++; $display("FAIL ifu_rd_data: got %h want 0000041300100093", ifu_rdata_l1); end
        step();
        #1;
        n_cmp++; if ({ifu_resp_valid_l1, lsu_resp_valid_l1, busy_l1} !== 3'b000) begin n_mis++; $display("FAIL ifu_rd_after: got %b want 000", {ifu_resp_valid_l1, lsu_resp_valid_l1, busy_l1}); end
        n_cmp++; if (ifu_rdata_l1 !== 64'h0000_0413_0010_0093) begin n_mis++; $display("FAIL ifu_rd_hold: got %h want 0000041300100093", ifu_rdata_l1); end
    endtask

    task automatic test_lsu_write();
        int n_men = 0;
        int n_resp = 0;
        int resp_at = -1;
        lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 64'h8000_1000;
        lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 8'h0F;
        #1;
        n_cmp++; if ({ifu_req_ready_l1, lsu_req_ready_l1} !== 2'b01) begin n_mis++; $display("FAIL wr_ready: got %b want 01", {ifu_req_ready_l1, lsu_req_ready_l1}); end
        step();
        lsu_req_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            if (men_l1) begin
                n_men++;
                n_cmp++; if ({mwen_l1, waddr_l1, wdata_l1, wmask_l1, raddr_l1} !== {1'b1, 64'h8000_1000, 64'hDEAD_BEEF, 8'h0F, 64'h0}) begin n_mis++; $display("FAIL wr_issue: got %h want %h", {mwen_l1, waddr_l1, wdata_l1, wmask_l1, raddr_l1}, {1'b1, 64'h8000_1000, 64'hDEAD_BEEF, 8'h0F, 64'h0}); end
            end
            if (lsu_resp_valid_l1) begin
                n_resp++;
                resp_at = c;
                n_cmp++; if (lsu_rdata_l1 !== 64'h0) begin n_mis++; $display("FAIL wr_rdata: got %h want 0", lsu_rdata_l1); end
            end
            step();
        end
        n_cmp++; if (n_men !== 1) begin n_mis++; $display("FAIL wr_men_count: got %0d want 1", n_men); end
        n_cmp++; if (n_resp !== 1 || resp_at !== 2) begin n_mis++; $display("FAIL wr_resp: got count %0d at %0d want 1 at 2", n_resp, resp_at); end
        lsu_wen = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [11:0] ifu_acc, lsu_acc, men_v, ifu_rv, lsu_rv;
        ifu_acc = '0; lsu_acc = '0; men_v = '0; ifu_rv = '0; lsu_rv = '0;
        do_reset();
        ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0000;
        lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 64'h8000_2000;
        for (int c = 0; c < 12; c++) begin
            #1;
            ifu_acc[c] = ifu_req_ready_l1;
            lsu_acc[c] = lsu_req_ready_l1;
            men_v[c]   = men_l1;
            ifu_rv[c]  = ifu_resp_valid_l1;
            lsu_rv[c]  = lsu_resp_valid_l1;
            step();
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        n_cmp++; if (ifu_acc !== 12'b0000_0100_0001) begin n_mis++; $display("FAIL b2b_ifu_accept: got %b want 000001000001", ifu_acc); end
        n_cmp++; if (lsu_acc !== 12'b0010_0000_1000) begin n_mis++; $display("FAIL b2b_lsu_accept: got %b want 001000001000", lsu_acc); end
        n_cmp++; if (men_v !== 12'b0100_1001_0010) begin n_mis++; $display("FAIL b2b_men: got %b want 010010010010", men_v); end
        n_cmp++; if ({ifu_rv, lsu_rv} !== {12'b0001_0000_0100, 12'b1000_0010_0000}) begin n_mis++; $display("FAIL b2b_resp: got %b want 000100000100100000100000", {ifu_rv, lsu_rv}); end
        n_cmp++; if (lsu_rdata_l1 !== 64'hC0FF_EE00_9234_7678) begin n_mis++; $display("FAIL b2b_lsu_rdata: got %h want c0ffee0092347678", lsu_rdata_l1); end
    endtask

    task automatic test_latency3();
        logic [5:0] rdy_v, men_v, busy_v, resp_v;
        rdy_v = '0; men_v = '0; busy_v = '0; resp_v = '0;
        do_reset();
        lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 64'h8000_0008;
        for (int c = 0; c < 6; c++) begin
            #1;
            rdy_v[c]  = lsu_req_ready_l3;
            men_v[c]  = men_l3;
            busy_v[c] = busy_l3;
            resp_v[c] = lsu_resp_valid_l3;
            if (men_l3) begin
                n_cmp++; if ({mwen_l3, raddr_l3} !== {1'b0, 64'h8000_0008}) begin n_mis++; $display("FAIL l3_issue: got %h want 080000008", {mwen_l3, raddr_l3}); end
            end
            if (lsu_resp_valid_l3) begin
                n_cmp++; if (lsu_rdata_l3 !== 64'hC0FF_EE00_9234_5670) begin n_mis++; $display("FAIL l3_rdata: got %h want c0ffee0092345670", lsu_rdata_l3); end
            end
            step();
            lsu_req_valid = 1'b0;
        end
        n_cmp++; if (rdy_v !== 6'b000001) begin n_mis++; $display("FAIL l3_ready: got %b want 000001", rdy_v); end
        n_cmp++; if (men_v !== 6'b001000) begin n_mis++; $display("FAIL l3_men: got %b want 001000", men_v); end
        n_cmp++; if (busy_v !== 6'b011110) begin n_mis++; $display("FAIL l3_busy: got %b want 011110", busy_v); end
        n_cmp++; if (resp_v !== 6'b010000) begin n_mis++; $display("FAIL l3_resp: got %b want 010000", resp_v); end
    endtask

    task automatic test_stop();
        int n_act = 0;
        int n_men = 0;
        int n_resp = 0;
        int n_rdy = 0;
        do_reset();
        stop = 1'b1; ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0000;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (ifu_req_ready_l1 || lsu_req_ready_l1 || busy_l1) n_act++;
            step();
        end
        n_cmp++; if (n_act !== 0) begin n_mis++; $display("FAIL stop_hold: got %0d active cycles want 0", n_act); end
        ifu_req_valid = 1'b0; stop = 1'b0;
        lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 64'h8000_3000;
        lsu_wdata = 64'h1122_3344_5566_7788; lsu_wmask = 8'hFF;
        #1;
        n_cmp++; if (lsu_req_ready_l3 !== 1'b1) begin n_mis++; $display("FAIL stop_wr_ready: got %b want 1", lsu_req_ready_l3); end
        step();
        stop = 1'b1; ifu_req_valid = 1'b1; lsu_wdata = '0; lsu_wmask = '0;
        for (int c = 1; c <= 12; c++) begin
            #1;
            if (ifu_req_ready_l3 || lsu_req_ready_l3) n_rdy++;
            if (lsu_resp_valid_l3) n_resp++;
            if (men_l3) begin
                n_men++;
                n_cmp++; if ({mwen_l3, waddr_l3, wdata_l3, wmask_l3} !== {1'b1, 64'h8000_3000, 64'h1122_3344_5566_7788, 8'hFF}) begin n_mis++; $display("FAIL stop_wr_issue: got %h want %h", {mwen_l3, waddr_l3, wdata_l3, wmask_l3}, {1'b1, 64'h8000_3000, 64'h1122_3344_5566_7788, 8'hFF}); end
            end
            step();
        end
        n_cmp++; if ({n_men, n_resp, n_rdy} !== {32'd1, 32'd1, 32'd0}) begin n_mis++; $display("FAIL stop_wr_counts: got men %0d resp %0d ready %0d want 1 1 0", n_men, n_resp, n_rdy); end
        n_cmp++; if (busy_l3 !== 1'b0) begin n_mis++; $display("FAIL stop_idle: got busy %b want 0", busy_l3); end
        stop = 1'b0;
        #1;
        n_cmp++; if ({ifu_req_ready_l3, lsu_req_ready_l3} !== 2'b10) begin n_mis++; $display("FAIL stop_release_tie: got %b want 10", {ifu_req_ready_l3, lsu_req_ready_l3}); end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n_act = 0;
        do_reset();
        lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 64'h8000_4000;
        lsu_wdata = 64'hCAFE_F00D; lsu_wmask = 8'h3C;
        #1;
        n_cmp++; if (lsu_req_ready_l3 !== 1'b1) begin n_mis++; $display("FAIL rmid_ready: got %b want 1", lsu_req_ready_l3); end
        step();
        lsu_req_valid = 1'b0; rst = 1'b1;
        #1;
        n_cmp++; if ({busy_l3, men_l3} !== 2'b10) begin n_mis++; $display("FAIL rmid_wait: got %b want 10", {busy_l3, men_l3}); end
        step();
        rst = 1'b0;
        #1;
        n_cmp++; if ({ifu_req_ready_l3, lsu_req_ready_l3, ifu_resp_valid_l3, lsu_resp_valid_l3, men_l3, mwen_l3, busy_l3} !== 7'b0) begin n_mis++; $display("FAIL rmid_ctrl: got %b want 0", {ifu_req_ready_l3, lsu_req_ready_l3, ifu_resp_valid_l3, lsu_resp_valid_l3, men_l3, mwen_l3, busy_l3}); end
        n_cmp++; if ({raddr_l3, waddr_l3, wdata_l3, wmask_l3, ifu_rdata_l3, lsu_rdata_l3} !== '0) begin n_mis++; $display("FAIL rmid_data: got %h want 0", {raddr_l3, waddr_l3, wdata_l3, wmask_l3, ifu_rdata_l3, lsu_rdata_l3}); end
        for (int c = 0; c < 5; c++) begin
            #1;
            if (men_l3 || mwen_l3 || lsu_resp_valid_l3 || ifu_resp_valid_l3 || busy_l3) n_act++;
            step();
        end
        n_cmp++; if (n_act !== 0) begin n_mis++; $display("FAIL rmid_quiet: got %0d active cycles want 0", n_act); end
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; lsu_wen = 1'b0;
        #1;
        n_cmp++; if ({ifu_req_ready_l3, lsu_req_ready_l3} !== 2'b10) begin n_mis++; $display("FAIL rmid_tie: got %b want 10", {ifu_req_ready_l3, lsu_req_ready_l3}); end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ifu_read();
        test_lsu_write();
        test_back_to_back();
        test_latency3();
        test_stop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single simulated memory port (men/mwen/raddr/waddr/wdata/wmask/rdata, backed by the pmem DPI block) between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Provides valid/ready request handshakes and one-cycle response pulses.
- Uses round-robin arbitration and configurable access latency.
- Issues exactly one men pulse per transaction, so each DPI write fires once.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width
- MASK_W, 8, write byte-mask width (DATA_W/8)
- LATENCY, 1, cycles from request accept to memory issue; legal range 1..15

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stop  in  1  halt; blocks new grants, in-flight transaction completes
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  IFU read address
- ifu_resp_valid  out  1  one-cycle IFU response pulse
- ifu_rdata  out  DATA_W  IFU read data, valid with ifu_resp_valid
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_wen  in  1  1 = write, 0 = read
- lsu_addr  in  ADDR_W  LSU address
- lsu_wdata  in  DATA_W  LSU write data
- lsu_wmask  in  MASK_W  LSU byte mask
- lsu_resp_valid  out  1  one-cycle LSU response pulse (reads and writes)
- lsu_rdata  out  DATA_W  LSU read data; 0 for writes
- men  out  1  memory enable to memory block
- mwen  out  1  memory write enable
- raddr  out  ADDR_W  memory read address
- waddr  out  ADDR_W  memory write address
- wdata  out  DATA_W  memory write data
- wmask  out  MASK_W  memory write mask
- rdata  in  DATA_W  memory read data, combinational from the memory block
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = LSU, so IFU wins the first tie.
- rst is synchronous and overrides everything. Mid-transaction reset goes to IDLE without issuing men or any resp pulse, and drops the latched request.
- States: IDLE, WAIT, ISSUE, RESP.
- IDLE:
  - If stop = 0 and at least one request is valid, grant one requester.
  - Only one requester: grant it.
  - Both requesting: grant the requester that is not last_grant.
  - Only the granted requester's req_ready is high, combinationally, in this cycle only. Handshake = valid && ready.
  - On accept: latch addr, wen (IFU forced 0), wdata, wmask, and grant id; update last_grant; load cnt = LATENCY-1.
  - Next state: WAIT if cnt != 0, else ISSUE.
  - stop = 1: both ready signals 0; remain in IDLE.
- WAIT: decrement cnt each cycle; go to ISSUE when cnt reaches 0. Both ready signals 0.
- ISSUE (exactly one cycle):
  - men = 1; mwen = latched wen.
  - Read: raddr = latched addr, waddr = 0, wdata = 0, wmask = 0.
  - Write: waddr = latched addr, wdata and wmask = latched values, raddr = 0.
  - Register rdata at end of cycle (reads only; writes register 0).
  - Next state: RESP.
- RESP (one cycle):
  - Granted master's resp_valid = 1 with the registered data; the other master's resp_valid = 0.
  - Next state: IDLE.
  - No new accept in RESP. Back-to-back requests therefore accept every LATENCY+2 cycles.
- Outside ISSUE: men, mwen, raddr, waddr, wdata, wmask are all 0.
- Latency: accept at cycle T; ISSUE at T+LATENCY; resp_valid at T+LATENCY+1.
- Responses have no backpressure; masters must sample on the pulse. ifu_rdata and lsu_rdata hold their last value between pulses.
- Requests that are valid but not granted must remain stable; the arbiter does not latch them.
- Address and mask are passed unmodified. Alignment and mask legality are the master's responsibility.
- stop rising while in WAIT, ISSUE, or RESP does not abort; the transaction completes, then the arbiter holds in IDLE.

Test Plan:
- Reset, LATENCY=1: IFU read 0x80000000, memory returns 0x00000413_00100093. Expect ifu_req_ready=1 at T; men=1, mwen=0, raddr=0x80000000 at T+1; ifu_resp_valid=1, ifu_rdata=0x0000041300100093 at T+2; lsu_resp_valid=0 throughout.
- LSU write addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F. Expect exactly one cycle with men=1, mwen=1, waddr=0x80001000, wmask=0x0F; lsu_resp_valid pulse with lsu_rdata=0.
- IFU and LSU held valid continuously from reset, LATENCY=1. Expect grant order IFU, LSU, IFU, LSU; accepts spaced 3 cycles apart; men asserted exactly 4 times in 12 cycles.
- LATENCY=3, LSU read 0x80000008. Expect men=0 for 2 WAIT cycles, men=1 at T+3, lsu_resp_valid at T+4; busy high from T+1 to T+4.
- stop=1 with IFU valid: ready stays 0 for 10 cycles. stop asserted during WAIT of an LSU write: write still issues once and responds; no further grants while stop=1.
- rst pulsed during WAIT of an LSU write. Expect no men/mwen assertion, no resp pulse, all outputs 0 the following cycle, and next tie grant to IFU.
